// File: rtl/weight_fetch_sequencer.sv
// Streams one layer's weight block from the 1-cycle-latency weight memory to the MAC datapath.
// Optional build macro WEIGHT_FETCH_MULTIPASS_EN adds num_passes for repeated passes over the block.
module weight_fetch_sequencer #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 72,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] num_words,
`ifdef WEIGHT_FETCH_MULTIPASS_EN
  input  logic [7:0]        num_passes,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DWIDTH-1:0] w_data,
  output logic              w_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LWIDTH:0]   CNT_ZERO = {(LWIDTH+1){1'b0}};
  localparam logic [LWIDTH:0]   CNT_ONE  = {{LWIDTH{1'b0}}, 1'b1};
  localparam logic [LWIDTH-1:0] LEN_ZERO = {LWIDTH{1'b0}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AWIDTH-1:0] base_r;
  logic [LWIDTH-1:0] len_r;
  logic [LWIDTH:0]   len_ext_s;
  logic [LWIDTH:0]   idx_r;
  logic [LWIDTH:0]   pop_cnt_r;
  logic              inflight_r;
  logic              done_r;
  logic [1:0]        occ_r;
  logic [1:0]        wr_ptr_r;
  logic [1:0]        rd_ptr_r;
  logic [DWIDTH-1:0] fifo_r [3];
  logic              start_s;
  logic              mem_read_s;
  logic              pop_s;
  logic              w_last_s;
  logic              idx_wrap_s;
  logic              last_pass_issue_s;
  logic              last_pass_pop_s;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign len_ext_s  = {1'b0, len_r};
  assign start_s    = (state_r == IDLE) && start;
  // Issue decision uses registered state only, so w_ready never reaches the memory port.
  assign mem_read_s = (state_r == FETCH) && (idx_r < len_ext_s) &&
                      (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);
  assign pop_s      = (occ_r != 2'd0) && w_ready;
  assign w_last_s   = (occ_r != 2'd0) && (pop_cnt_r == len_ext_s - CNT_ONE);
  assign idx_wrap_s = (idx_r == len_ext_s - CNT_ONE) && !last_pass_issue_s;

`ifdef WEIGHT_FETCH_MULTIPASS_EN
  logic [7:0] passes_r;
  logic [7:0] iss_pass_r;
  logic [7:0] pop_pass_r;

  assign last_pass_issue_s = (iss_pass_r == passes_r - 8'd1);
  assign last_pass_pop_s   = (pop_pass_r == passes_r - 8'd1);

  // Pass bookkeeping: issue side and consume side advance independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      passes_r   <= 8'd0;
      iss_pass_r <= 8'd0;
      pop_pass_r <= 8'd0;
    end else if (start_s) begin
      passes_r   <= (num_passes == 8'd0) ? 8'd1 : num_passes;
      iss_pass_r <= 8'd0;
      pop_pass_r <= 8'd0;
    end else begin
      if (mem_read_s && idx_wrap_s) begin
        iss_pass_r <= iss_pass_r + 8'd1;
      end
      if (pop_s && w_last_s) begin
        pop_pass_r <= pop_pass_r + 8'd1;
      end
    end
  end
`else
  assign last_pass_issue_s = 1'b1;
  assign last_pass_pop_s   = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && (num_words != LEN_ZERO)) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (idx_r == len_ext_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        if (pop_s && w_last_s && last_pass_pop_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Command latch, issue/pop counters, in-flight flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r     <= {AWIDTH{1'b0}};
      len_r      <= LEN_ZERO;
      idx_r      <= CNT_ZERO;
      pop_cnt_r  <= CNT_ZERO;
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      inflight_r <= mem_read_s;
      if (start_s) begin
        base_r    <= base_addr;
        len_r     <= num_words;
        idx_r     <= CNT_ZERO;
        pop_cnt_r <= CNT_ZERO;
        done_r    <= (num_words == LEN_ZERO);
      end else begin
        if (mem_read_s) begin
          idx_r <= idx_wrap_s ? CNT_ZERO : idx_r + CNT_ONE;
        end
        if (pop_s) begin
          if (w_last_s) begin
            pop_cnt_r <= CNT_ZERO;
            done_r    <= last_pass_pop_s;
          end else begin
            pop_cnt_r <= pop_cnt_r + CNT_ONE;
          end
        end
      end
    end
  end

  // Three-entry output buffer; the in-flight flag is the push strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r    <= 2'd0;
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        fifo_r[i] <= {DWIDTH{1'b0}};
      end
    end else begin
      if (inflight_r) begin
        fifo_r[wr_ptr_r] <= mem_dout;
        wr_ptr_r         <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({inflight_r, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign busy     = (state_r != IDLE);
  assign done     = done_r;
  assign mem_read = mem_read_s;
  assign mem_addr = base_r + AWIDTH'(idx_r);
  assign w_valid  = (occ_r != 2'd0);
  assign w_data   = fifo_r[rd_ptr_r];
  assign w_last   = w_last_s;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench for weight_fetch_sequencer: vector table plus reset, ignored-start and multipass sequences.
module tb_weight_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic [15:0] num_words = 16'h0000;
  logic        busy, done, mem_read, w_valid, w_last;
  logic [15:0] mem_addr;
  logic [71:0] mem_dout = 72'h0;
  logic        w_ready = 1'b0;
  logic [71:0] w_data;
`ifdef WEIGHT_FETCH_MULTIPASS_EN
  logic [7:0]  num_passes = 8'd0;
`endif

  weight_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
`ifdef WEIGHT_FETCH_MULTIPASS_EN
    .num_passes(num_passes),
`endif
    .busy(busy), .done(done), .mem_read(mem_read), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outstanding = 0;
  int busy_cnt = 0;
  int stall_cnt = 0;
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  logic [71:0] pop_d_q[$];
  logic        pop_l_q[$];
  int          pop_cyc_q[$];
  int          done_cyc_q[$];

  function automatic logic [71:0] mem_word(input logic [15:0] a);
    return {8'h5C, a, ~a, a ^ 16'h1234, a + 16'h0101};
  endfunction

  function automatic logic ready_at(input int mode, input int k);
    logic [7:0] pat;
    pat = 8'b10101001;
    return (mode == 0) ? 1'b1 : pat[k % 8];
  endfunction

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read) mem_dout <= mem_word(mem_addr);
  end

  // Monitor: records traffic and checks that buffered plus in-flight words never exceed three.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (outstanding > 3 || (outstanding == 3 && mem_read)) begin
        errors++;
        $display("FAIL occupancy: outstanding %0d mem_read %0b at cycle %0d, limit 3 with no read at 3", outstanding, mem_read, cyc);
      end
      if (outstanding == 3) stall_cnt++;
      if (mem_read) begin
        rd_q.push_back(mem_addr);
        rd_cyc_q.push_back(cyc);
        outstanding++;
      end
      if (w_valid && w_ready) begin
        pop_d_q.push_back(w_data);
        pop_l_q.push_back(w_last);
        pop_cyc_q.push_back(cyc);
        outstanding--;
      end
      if (done) done_cyc_q.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete(); rd_cyc_q.delete();
    pop_d_q.delete(); pop_l_q.delete(); pop_cyc_q.delete();
    done_cyc_q.delete();
    outstanding = 0;
    busy_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic wait_done(input int mode, input int budget, input string nm);
    int k;
    k = 1;
    while (done_cyc_q.size() == 0 && k < budget) begin
      w_ready = ready_at(mode, k);
      tick();
      k++;
    end
    w_ready = 1'b1;
    chk_i({nm, " done_seen"}, int'(done_cyc_q.size() != 0), 1);
  endtask

  task automatic run_cmd(input logic [15:0] b, input logic [15:0] n, input int mode, output int t);
    clear_mon();
    base_addr = b;
    num_words = n;
    w_ready   = ready_at(mode, 0);
    start     = 1'b1;
    t         = cyc;
    tick();
    start = 1'b0;
    wait_done(mode, 300, "cmd");
  endtask

  task automatic check_stream(input logic [15:0] b, input int n, input string nm);
    logic [15:0] a;
    chk_i({nm, " reads"}, rd_q.size(), n);
    chk_i({nm, " pops"}, pop_d_q.size(), n);
    for (int i = 0; i < n && i < rd_q.size(); i++) begin
      a = b + 16'(i);
      chk_v($sformatf("%s addr%0d", nm, i), 72'(rd_q[i]), 72'(a));
    end
    for (int i = 0; i < n && i < pop_d_q.size(); i++) begin
      a = b + 16'(i);
      chk_v($sformatf("%s data%0d", nm, i), pop_d_q[i], mem_word(a));
      chk_i($sformatf("%s last%0d", nm, i), int'(pop_l_q[i]), int'(i == n - 1));
    end
    chk_i({nm, " done_count"}, done_cyc_q.size(), 1);
    chk_i({nm, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] n;
    int          mode;
    logic [15:0] exp_last_addr;
    int          exp_done_lat;
  } vec_t;

  vec_t vecs[5];
  int   t0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0010, 16'd4, 0, 16'h0013, 7};
    vecs[1] = '{16'hFFFE, 16'd4, 0, 16'h0001, 7};
    vecs[2] = '{16'h0100, 16'd6, 1, 16'h0105, -1};
    vecs[3] = '{16'h0200, 16'd0, 0, 16'h0000, 1};
    vecs[4] = '{16'h0300, 16'd1, 0, 16'h0300, 4};

    rst = 1'b1;
    tick();
    tick();
    chk_v("reset outputs", {busy, done, mem_read, w_valid, w_last, 16'(mem_addr), 51'h0},
          72'h0);
    chk_v("reset w_data", w_data, 72'h0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].base, vecs[v].n, vecs[v].mode, t0);
      check_stream(vecs[v].base, int'(vecs[v].n), $sformatf("vec%0d", v));
      if (vecs[v].exp_done_lat >= 0 && done_cyc_q.size() != 0)
        chk_i($sformatf("vec%0d done_lat", v), done_cyc_q[0] - t0, vecs[v].exp_done_lat);
      if (vecs[v].n != 16'd0 && rd_q.size() != 0)
        chk_v($sformatf("vec%0d last_addr", v), 72'(rd_q[rd_q.size()-1]), 72'(vecs[v].exp_last_addr));
      if (vecs[v].n == 16'd0)
        chk_i($sformatf("vec%0d busy_cycles", v), busy_cnt, 0);
      if (vecs[v].mode == 0 && vecs[v].n != 16'd0 && rd_cyc_q.size() != 0 && pop_cyc_q.size() != 0) begin
        chk_i($sformatf("vec%0d first_read_lat", v), rd_cyc_q[0] - t0, 1);
        chk_i($sformatf("vec%0d first_pop_lat", v), pop_cyc_q[0] - t0, 3);
        chk_i($sformatf("vec%0d last_pop_lat", v), pop_cyc_q[pop_cyc_q.size()-1] - t0, 2 + int'(vecs[v].n));
      end
      if (vecs[v].mode == 1)
        chk_i($sformatf("vec%0d stalled", v), int'(stall_cnt > 0), 1);
      tick();
    end

    // Second start while busy must be ignored.
    clear_mon();
    base_addr = 16'h0400; num_words = 16'd10; w_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    base_addr = 16'h0700; num_words = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 200, "ignore");
    for (int i = 0; i < 5; i++) tick();
    check_stream(16'h0400, 10, "ignore");

    // Reset while the third word is in flight, then a clean 2-word command.
    clear_mon();
    base_addr = 16'h0500; num_words = 16'd8; w_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_v("midreset outputs", {busy, done, mem_read, w_valid, w_last, 16'(mem_addr), 51'h0},
          72'h0);
    chk_v("midreset w_data", w_data, 72'h0);
    tick();
    run_cmd(16'h0600, 16'd2, 0, t0);
    check_stream(16'h0600, 2, "postreset");
    tick();

`ifdef WEIGHT_FETCH_MULTIPASS_EN
    num_passes = 8'd2;
    run_cmd(16'h0040, 16'd3, 0, t0);
    num_passes = 8'd0;
    chk_i("mp reads", rd_q.size(), 6);
    chk_i("mp pops", pop_d_q.size(), 6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++) begin
      chk_v($sformatf("mp addr%0d", i), 72'(rd_q[i]), 72'(16'h0040 + 16'(i % 3)));
      chk_i($sformatf("mp read_cyc%0d", i), rd_cyc_q[i] - t0, i + 1);
    end
    for (int i = 0; i < 6 && i < pop_d_q.size(); i++) begin
      chk_v($sformatf("mp data%0d", i), pop_d_q[i], mem_word(16'h0040 + 16'(i % 3)));
      chk_i($sformatf("mp last%0d", i), int'(pop_l_q[i]), int'(i == 2 || i == 5));
    end
    for (int i = 0; i < 4; i++) tick();
    chk_i("mp done_count", done_cyc_q.size(), 1);
    if (done_cyc_q.size() != 0) chk_i("mp done_lat", done_cyc_q[0] - t0, 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
